// File: rtl/event_encoder.sv
// event_encoder: collects single-cycle event pulses into a pending set and serves them
// as binary indices over a valid/ready stream. Define ROUND_ROBIN_EN for rotating priority.
module event_encoder #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  evt_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic [N-1:0]  pending,
    output logic          overflow
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e   slot_q, slot_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic [N-1:0]  pending_q, pending_d;
    logic          overflow_q, overflow_d;

    logic          load;
    logic          pick_valid;
    logic [IW-1:0] sel;
    logic [N-1:0]  clr;

    // Lowest set bit of v: {found, index}.
    function automatic logic [IW:0] first_set(input logic [N-1:0] v);
        logic [IW:0] res;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (v[k]) begin
                res = {1'b1, IW'(k)};
            end
        end
        return res;
    endfunction

`ifdef ROUND_ROBIN_EN
    logic [IW-1:0] rr_last_q, rr_last_d;
    logic [IW-1:0] rr_start;
    logic [N-1:0]  pend_rot;
    logic [IW:0]   rot_hit;
    logic [IW:0]   sel_sum;

    // Rotate pending so the search start sits at bit 0, then map the hit back.
    always_comb begin
        rr_start   = (rr_last_q == IW'(N - 1)) ? '0 : rr_last_q + IW'(1);
        pend_rot   = N'({pending_q, pending_q} >> rr_start);
        rot_hit    = first_set(pend_rot);
        pick_valid = rot_hit[IW];
        sel_sum    = {1'b0, rr_start} + {1'b0, rot_hit[IW-1:0]};
        sel        = (sel_sum >= (IW+1)'(N)) ? IW'(sel_sum - (IW+1)'(N))
                                             : sel_sum[IW-1:0];
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (load && pick_valid) begin
            rr_last_d = sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= IW'(N - 1);
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    logic [IW:0] fixed_hit;

    always_comb begin
        fixed_hit  = first_set(pending_q);
        pick_valid = fixed_hit[IW];
        sel        = fixed_hit[IW-1:0];
    end
`endif

    // NOTE: every signal gets its default before any branch, so no path can infer a latch.
    always_comb begin
        slot_d    = slot_q;
        out_idx_d = out_idx_q;
        clr       = '0;
        load      = (slot_q == SLOT_EMPTY) || out_ready;
        if (load) begin
            if (pick_valid) begin
                slot_d    = SLOT_FULL;
                out_idx_d = sel;
                clr       = N'(1) << sel;
            end else begin
                slot_d    = SLOT_EMPTY;
            end
        end
        // A bit cleared into the slot and re-raised in the same cycle stays pending.
        pending_d  = (pending_q & ~clr) | evt_in;
        overflow_d = |(evt_in & pending_q & ~clr);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= SLOT_EMPTY;
            out_idx_q  <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            out_idx_q  <= out_idx_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = (slot_q == SLOT_FULL);
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
